// File: rtl/spp_pkg.sv
// Shared types and default widths for the sparse pair packer.
// Imported by sparse_pair_packer and spp_window_pick.
package spp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int SPP_DW = 16;
    localparam int SPP_AW = 21;
    localparam int SPP_PW = 9;

    typedef struct packed {
        logic [SPP_AW-1:0] addr;
        logic [SPP_DW-1:0] w;
        logic [SPP_DW-1:0] ia;
    } slot_t;

endpackage

// File: rtl/spp_window_pick.sv
// Priority picker over the look-ahead window: lowest k that is both valid and in range.
import spp_pkg::*;

module spp_window_pick #(
    parameter int LOOKAHEAD = 3,
    parameter int KW        = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1
) (
    input  logic [LOOKAHEAD-1:0] valid,
    input  logic [LOOKAHEAD-1:0] in_range,
    output logic                 found,
    output logic [KW-1:0]        k
);

    always_comb begin
        found = 1'b0;
        k     = '0;
        // Descending scan so the lowest eligible index is the one left standing.
        for (int i = LOOKAHEAD - 1; i >= 0; i--) begin
            if (valid[i] && in_range[i]) begin
                found = 1'b1;
                k     = KW'(i);
            end
        end
    end

endmodule

// File: rtl/sparse_pair_packer.sv
// Compacts sparse (weight, activation, address) triples into two LANES-deep ping-pong banks.
// Optional SPP_STATS_EN adds o_nnz_count / o_stall_cycles job statistics.
import spp_pkg::*;

// state | meaning
// IDLE  | waiting for i_start
// SCAN  | walking the weight vector, one pick per cycle
// FLUSH | zero-padding the partial active bank once it is free
// DRAIN | waiting for the consumer to ack every bank, then finish
module sparse_pair_packer #(
    parameter int W_LEN     = 27,
    parameter int IA_CH     = 64,
    parameter int LANES     = 3,
    parameter int LOOKAHEAD = 3,
    parameter int DW        = SPP_DW,
    parameter int AW        = SPP_AW,
    parameter int PW        = SPP_PW
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_start,
    input  logic [$clog2(W_LEN):0]              i_w_len,
    input  logic [W_LEN-1:0]                    i_valid_buf,
    input  logic [W_LEN-1:0][AW-1:0]            i_addr_buf,
    input  logic [W_LEN-1:0][PW-1:0]            i_pos_buf,
    input  logic [W_LEN-1:0][DW-1:0]            i_w_data,
    input  logic [IA_CH-1:0][DW-1:0]            i_ia_data,
    input  logic [1:0]                          i_bank_ack,
    output logic [1:0]                          o_bank_valid,
    output logic [1:0][LANES-1:0][AW-1:0]       o_addr,
    output logic [1:0][LANES-1:0][DW-1:0]       o_w_data,
    output logic [1:0][LANES-1:0][DW-1:0]       o_ia_data,
    output logic                                o_busy,
    output logic                                o_finish
`ifdef SPP_STATS_EN
    ,
    output logic [$clog2(W_LEN):0]              o_nnz_count,
    output logic [15:0]                         o_stall_cycles
`endif
);

    localparam int EW   = $clog2(W_LEN);
    localparam int XW   = $clog2(W_LEN + LOOKAHEAD + 1) + 1;
    localparam int CW   = $clog2(IA_CH);
    localparam int LW   = $clog2(LANES);
    localparam int KW   = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    state_t            state, state_n;
    logic [XW-1:0]     idx, idx_n;
    logic [LW-1:0]     wr_pos, wr_pos_n;
    logic              bank, bank_n;
    logic [1:0]        valid_n;
    logic              finish_n, wr_en, pad_en, stall;

    logic [XW-1:0]          w_len_x;
    logic [XW-1:0]          win_idx [LOOKAHEAD];
    logic [LOOKAHEAD-1:0]   win_valid, win_range;
    logic                   pick_found;
    logic [KW-1:0]          pick_k;
    logic [XW-1:0]          sel_idx;
    logic [EW-1:0]          sel_e;
    logic [PW-1:0]          sel_pos;
    logic [DW-1:0]          sel_ia;

    assign w_len_x = XW'(i_w_len);
    assign o_busy  = (state != IDLE);

    // Indices past i_w_len (or the buffer) are masked before the buffer is touched.
    always_comb begin
        for (int k = 0; k < LOOKAHEAD; k++) begin
            win_idx[k]   = idx + XW'(k);
            win_range[k] = (win_idx[k] < w_len_x) && (win_idx[k] < XW'(W_LEN));
            win_valid[k] = win_range[k] ? i_valid_buf[win_idx[k][EW-1:0]] : 1'b0;
        end
    end

    spp_window_pick #(
        .LOOKAHEAD (LOOKAHEAD),
        .KW        (KW)
    ) u_pick (
        .valid    (win_valid),
        .in_range (win_range),
        .found    (pick_found),
        .k        (pick_k)
    );

    assign sel_idx = idx + XW'(pick_k);
    assign sel_e   = sel_idx[EW-1:0];
    assign sel_pos = i_pos_buf[sel_e];
    assign sel_ia  = (sel_pos < PW'(IA_CH)) ? i_ia_data[sel_pos[CW-1:0]] : '0;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        wr_pos_n = wr_pos;
        bank_n   = bank;
        valid_n  = o_bank_valid & ~i_bank_ack;
        finish_n = 1'b0;
        wr_en    = 1'b0;
        pad_en   = 1'b0;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n  = SCAN;
                    idx_n    = '0;
                    wr_pos_n = '0;
                    bank_n   = 1'b0;
                end
            end
            SCAN: begin
                if (idx >= w_len_x) begin
                    state_n = (wr_pos != '0) ? FLUSH : DRAIN;
                end else if (o_bank_valid[bank]) begin
                    stall = 1'b1;
                end else if (pick_found) begin
                    wr_en = 1'b1;
                    idx_n = sel_idx + XW'(1);
                    if (wr_pos == LAST) begin
                        valid_n[bank] = 1'b1;
                        bank_n        = ~bank;
                        wr_pos_n      = '0;
                    end else begin
                        wr_pos_n = wr_pos + LW'(1);
                    end
                end else begin
                    idx_n = idx + XW'(LOOKAHEAD);
                end
            end
            FLUSH: begin
                if (o_bank_valid[bank]) begin
                    stall = 1'b1;
                end else begin
                    pad_en        = 1'b1;
                    valid_n[bank] = 1'b1;
                    bank_n        = ~bank;
                    wr_pos_n      = '0;
                    state_n       = DRAIN;
                end
            end
            DRAIN: begin
                // Same-cycle acks count, so finish follows the last ack by one cycle.
                if (valid_n == 2'b00) begin
                    finish_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            wr_pos       <= '0;
            bank         <= 1'b0;
            o_bank_valid <= '0;
            o_finish     <= 1'b0;
            o_addr       <= '0;
            o_w_data     <= '0;
            o_ia_data    <= '0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            wr_pos       <= wr_pos_n;
            bank         <= bank_n;
            o_bank_valid <= valid_n;
            o_finish     <= finish_n;
            if (wr_en) begin
                o_addr[bank][wr_pos]    <= i_addr_buf[sel_e];
                o_w_data[bank][wr_pos]  <= i_w_data[sel_e];
                o_ia_data[bank][wr_pos] <= sel_ia;
            end
            if (pad_en) begin
                for (int j = 0; j < LANES; j++) begin
                    if (LW'(j) >= wr_pos) begin
                        o_addr[bank][j]    <= '0;
                        o_w_data[bank][j]  <= '0;
                        o_ia_data[bank][j] <= '0;
                    end
                end
            end
        end
    end

`ifdef SPP_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_nnz_count    <= '0;
            o_stall_cycles <= '0;
        end else if (state == IDLE && i_start) begin
            o_nnz_count    <= '0;
            o_stall_cycles <= '0;
        end else begin
            if (wr_en)
                o_nnz_count <= o_nnz_count + 1'b1;
            if (stall && o_stall_cycles != 16'hFFFF)
                o_stall_cycles <= o_stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sparse_pair_packer.sv
// Directed bench for sparse_pair_packer: packing, stalls, tail flush, empty job and mid-job reset.
module tb_sparse_pair_packer;

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic [5:0]               w_len;
    logic [26:0]              valid_buf;
    logic [26:0][20:0]        addr_buf;
    logic [26:0][8:0]         pos_buf;
    logic [26:0][15:0]        w_data;
    logic [63:0][15:0]        ia_data;
    logic [1:0]               bank_ack;
    logic [1:0]               bank_valid;
    logic [1:0][2:0][20:0]    out_addr;
    logic [1:0][2:0][15:0]    out_w;
    logic [1:0][2:0][15:0]    out_ia;
    logic                     busy;
    logic                     finish;
`ifdef SPP_STATS_EN
    logic [5:0]               nnz_count;
    logic [15:0]              stall_cycles;
`endif

    int checks = 0;
    int passed = 0;

    // Per-job observations filled by run_job
    int               first_v [2];
    int               cyc_v   [2];
    int               cyc_fin;
    logic             busy_c1;
    logic             fin_after;
    logic [2:0][20:0] snap_addr [2];
    logic [2:0][15:0] snap_w    [2];
    logic [2:0][15:0] snap_ia   [2];

    sparse_pair_packer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_w_len      (w_len),
        .i_valid_buf  (valid_buf),
        .i_addr_buf   (addr_buf),
        .i_pos_buf    (pos_buf),
        .i_w_data     (w_data),
        .i_ia_data    (ia_data),
        .i_bank_ack   (bank_ack),
        .o_bank_valid (bank_valid),
        .o_addr       (out_addr),
        .o_w_data     (out_w),
        .o_ia_data    (out_ia),
        .o_busy       (busy),
        .o_finish     (finish)
`ifdef SPP_STATS_EN
        ,
        .o_nnz_count    (nnz_count),
        .o_stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected slot contents for entry e; e < 0 means a zero pad slot.
    function automatic logic [2:0][20:0] pack_a(int e0, int e1, int e2);
        int e [3];
        logic [2:0][20:0] r;
        e = '{e0, e1, e2};
        for (int j = 0; j < 3; j++) r[j] = (e[j] < 0) ? 21'd0 : 21'h10000 + 21'(e[j]);
        return r;
    endfunction

    function automatic logic [2:0][15:0] pack_w(int e0, int e1, int e2);
        int e [3];
        logic [2:0][15:0] r;
        e = '{e0, e1, e2};
        for (int j = 0; j < 3; j++) r[j] = (e[j] < 0) ? 16'd0 : 16'(-1 - e[j]);
        return r;
    endfunction

    function automatic logic [2:0][15:0] pack_ia(int e0, int e1, int e2);
        int e [3];
        logic [2:0][15:0] r;
        e = '{e0, e1, e2};
        for (int j = 0; j < 3; j++) r[j] = (e[j] < 0) ? 16'd0 : 16'h0A00 + 16'((e[j] * 5) % 64);
        return r;
    endfunction

    // Starts a job and runs it to o_finish (bounded); acks banks from ack_from on,
    // snapshots the first valid of each bank at or after cap_from.
    task automatic run_job(input logic [5:0] len, input logic [26:0] vbuf,
                           input int ack_from, input int cap_from);
        int cyc;
        first_v = '{-1, -1};
        cyc_v   = '{-1, -1};
        cyc_fin = -1;
        busy_c1 = 1'b0;
        @(negedge clk);
        w_len     = len;
        valid_buf = vbuf;
        start     = 1'b1;
        cyc       = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) busy_c1 = busy;
            for (int b = 0; b < 2; b++) begin
                if (bank_valid[b] && first_v[b] < 0) first_v[b] = cyc;
                if (bank_valid[b] && cyc_v[b] < 0 && cyc >= cap_from) begin
                    cyc_v[b]     = cyc;
                    snap_addr[b] = out_addr[b];
                    snap_w[b]    = out_w[b];
                    snap_ia[b]   = out_ia[b];
                end
            end
            if (finish) begin
                cyc_fin  = cyc;
                bank_ack = 2'b00;
                break;
            end
            bank_ack = (cyc >= ack_from) ? bank_valid : 2'b00;
        end
        bank_ack = 2'b00;
        @(negedge clk);
        fin_after = finish;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bank_valid !== 2'b00) $display("FAIL reset_valid got %b want 00", bank_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (finish !== 1'b0) $display("FAIL reset_finish got %b want 0", finish); else passed++;
        checks++; if (out_addr !== '0 || out_w !== '0 || out_ia !== '0)
            $display("FAIL reset_data got %h/%h/%h want 0", out_addr, out_w, out_ia); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_job(6'd9, 27'b110001101, 0, 0);
        checks++; if (busy_c1 !== 1'b1) $display("FAIL basic_busy got %b want 1", busy_c1); else passed++;
        checks++; if (cyc_v[0] != 4) $display("FAIL basic_b0_cycle got %0d want 4", cyc_v[0]); else passed++;
        checks++; if (snap_addr[0] !== pack_a(0, 2, 3)) $display("FAIL basic_b0_addr got %h want %h", snap_addr[0], pack_a(0, 2, 3)); else passed++;
        checks++; if (snap_w[0] !== pack_w(0, 2, 3)) $display("FAIL basic_b0_w got %h want %h", snap_w[0], pack_w(0, 2, 3)); else passed++;
        checks++; if (snap_ia[0] !== pack_ia(0, 2, 3)) $display("FAIL basic_b0_ia got %h want %h", snap_ia[0], pack_ia(0, 2, 3)); else passed++;
        checks++; if (cyc_v[1] != 9) $display("FAIL basic_b1_cycle got %0d want 9", cyc_v[1]); else passed++;
        checks++; if (snap_addr[1] !== pack_a(7, 8, -1)) $display("FAIL basic_b1_addr got %h want %h", snap_addr[1], pack_a(7, 8, -1)); else passed++;
        checks++; if (snap_w[1] !== pack_w(7, 8, -1)) $display("FAIL basic_b1_w got %h want %h", snap_w[1], pack_w(7, 8, -1)); else passed++;
        checks++; if (snap_ia[1] !== pack_ia(7, 8, -1)) $display("FAIL basic_b1_ia got %h want %h", snap_ia[1], pack_ia(7, 8, -1)); else passed++;
        checks++; if (cyc_fin != 10) $display("FAIL basic_finish_cycle got %0d want 10", cyc_fin); else passed++;
        checks++; if (fin_after !== 1'b0) $display("FAIL basic_finish_pulse got %b want 0", fin_after); else passed++;
`ifdef SPP_STATS_EN
        checks++; if (nnz_count !== 6'd5) $display("FAIL basic_nnz got %0d want 5", nnz_count); else passed++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL basic_stall got %0d want 0", stall_cycles); else passed++;
`endif
    endtask

    task automatic test_backpressure();
        run_job(6'd27, 27'h7FFFFFF, 20, 21);
        checks++; if (first_v[0] != 4) $display("FAIL bp_first_b0 got %0d want 4", first_v[0]); else passed++;
        checks++; if (first_v[1] != 7) $display("FAIL bp_first_b1 got %0d want 7", first_v[1]); else passed++;
        checks++; if (cyc_v[0] != 24) $display("FAIL bp_refill_b0_cycle got %0d want 24", cyc_v[0]); else passed++;
        checks++; if (snap_addr[0] !== pack_a(6, 7, 8)) $display("FAIL bp_refill_b0_addr got %h want %h", snap_addr[0], pack_a(6, 7, 8)); else passed++;
        checks++; if (snap_ia[0] !== pack_ia(6, 7, 8)) $display("FAIL bp_refill_b0_ia got %h want %h", snap_ia[0], pack_ia(6, 7, 8)); else passed++;
        checks++; if (cyc_v[1] != 27) $display("FAIL bp_refill_b1_cycle got %0d want 27", cyc_v[1]); else passed++;
        checks++; if (snap_w[1] !== pack_w(9, 10, 11)) $display("FAIL bp_refill_b1_w got %h want %h", snap_w[1], pack_w(9, 10, 11)); else passed++;
        checks++; if (cyc_fin != 44) $display("FAIL bp_finish_cycle got %0d want 44", cyc_fin); else passed++;
`ifdef SPP_STATS_EN
        checks++; if (nnz_count !== 6'd27) $display("FAIL bp_nnz got %0d want 27", nnz_count); else passed++;
        checks++; if (stall_cycles !== 16'd14) $display("FAIL bp_stall got %0d want 14", stall_cycles); else passed++;
`endif
    endtask

    task automatic test_tail_flush();
        // Entries 5 and 6 are flagged but lie beyond w_len and must never be packed.
        run_job(6'd5, 27'b1110000, 0, 0);
        checks++; if (cyc_v[0] != 5) $display("FAIL tail_b0_cycle got %0d want 5", cyc_v[0]); else passed++;
        checks++; if (snap_addr[0] !== pack_a(4, -1, -1)) $display("FAIL tail_addr got %h want %h", snap_addr[0], pack_a(4, -1, -1)); else passed++;
        checks++; if (snap_w[0] !== pack_w(4, -1, -1)) $display("FAIL tail_w got %h want %h", snap_w[0], pack_w(4, -1, -1)); else passed++;
        checks++; if (snap_ia[0] !== pack_ia(4, -1, -1)) $display("FAIL tail_ia got %h want %h", snap_ia[0], pack_ia(4, -1, -1)); else passed++;
        checks++; if (first_v[1] != -1) $display("FAIL tail_b1_idle got %0d want -1", first_v[1]); else passed++;
        checks++; if (cyc_fin != 6) $display("FAIL tail_finish_cycle got %0d want 6", cyc_fin); else passed++;
    endtask

    task automatic test_empty_job();
        run_job(6'd0, 27'h7FFFFFF, 0, 0);
        checks++; if (busy_c1 !== 1'b1) $display("FAIL empty_busy got %b want 1", busy_c1); else passed++;
        checks++; if (first_v[0] != -1 || first_v[1] != -1)
            $display("FAIL empty_no_valid got %0d,%0d want -1,-1", first_v[0], first_v[1]); else passed++;
        checks++; if (cyc_fin != 3) $display("FAIL empty_finish_cycle got %0d want 3", cyc_fin); else passed++;
        checks++; if (fin_after !== 1'b0) $display("FAIL empty_finish_pulse got %b want 0", fin_after); else passed++;
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        w_len     = 6'd27;
        valid_buf = 27'h7FFFFFF;
        start     = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (bank_valid !== 2'b11) $display("FAIL midrst_pre_valid got %b want 11", bank_valid); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (bank_valid !== 2'b00) $display("FAIL midrst_valid got %b want 00", bank_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
        checks++; if (out_addr !== '0 || out_w !== '0 || out_ia !== '0)
            $display("FAIL midrst_data got %h/%h/%h want 0", out_addr, out_w, out_ia); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        run_job(6'd3, 27'b111, 0, 0);
        checks++; if (cyc_v[0] != 4) $display("FAIL midrst_b0_cycle got %0d want 4", cyc_v[0]); else passed++;
        checks++; if (snap_addr[0] !== pack_a(0, 1, 2)) $display("FAIL midrst_b0_addr got %h want %h", snap_addr[0], pack_a(0, 1, 2)); else passed++;
        checks++; if (first_v[1] != -1) $display("FAIL midrst_b1_idle got %0d want -1", first_v[1]); else passed++;
        checks++; if (cyc_fin != 6) $display("FAIL midrst_finish_cycle got %0d want 6", cyc_fin); else passed++;
`ifdef SPP_STATS_EN
        checks++; if (nnz_count !== 6'd3) $display("FAIL midrst_nnz got %0d want 3", nnz_count); else passed++;
`endif
    endtask

    initial begin
        start     = 1'b0;
        w_len     = '0;
        valid_buf = '0;
        bank_ack  = 2'b00;
        for (int e = 0; e < 27; e++) begin
            addr_buf[e] = 21'h10000 + 21'(e);
            w_data[e]   = 16'(-1 - e);
            pos_buf[e]  = 9'((e * 5) % 64);
        end
        for (int c = 0; c < 64; c++) ia_data[c] = 16'h0A00 + 16'(c);

        test_reset();
        test_basic();
        test_backpressure();
        test_tail_flush();
        test_empty_job();
        test_reset_mid_job();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
